// File: rtl/dcache_dv_flush_engine_if.sv
// Handshake bundle between the flush engine, the D/V status buffer and the
// write-back port. The engine takes the master modport.
interface dcache_dv_flush_engine_if #(
  parameter int SET_W = 5,
  parameter int WAY_W = 3
);
  localparam int AW = SET_W + WAY_W;
  localparam int RW = 2 * (2 ** WAY_W);

  logic          i_flush_req;
  logic          o_flush_busy;
  logic          o_flush_done;
  logic [AW-1:0] o_dv_addr_8;
  logic          o_dv_write_enable;
  logic [1:0]    o_dv_data_in_2;
  logic [RW-1:0] i_dv_row_16;
  logic          o_wb_req;
  logic [AW-1:0] o_wb_addr_8;
  logic          i_wb_ack;

  modport master (
    input  i_flush_req, i_dv_row_16, i_wb_ack,
    output o_flush_busy, o_flush_done, o_dv_addr_8, o_dv_write_enable,
           o_dv_data_in_2, o_wb_req, o_wb_addr_8
  );

  modport slave (
    output i_flush_req, i_dv_row_16, i_wb_ack,
    input  o_flush_busy, o_flush_done, o_dv_addr_8, o_dv_write_enable,
           o_dv_data_in_2, o_wb_req, o_wb_addr_8
  );
endinterface

// File: rtl/dcache_dv_flush_engine.sv
// Dcache D/V flush sequencer: writes back every dirty-valid line, set by set.
// Define DCACHE_FLUSH_INVALIDATE_EN to turn the flush into a full invalidate.
module dcache_dv_flush_engine #(
  parameter int SET_W = 5,
  parameter int WAY_W = 3
) (
  input  logic                    fire,
  input  logic                    rstn,
  dcache_dv_flush_engine_if.master bus
);

  localparam int NWAY = 2 ** WAY_W;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam logic [1:0] CLR_VAL = 2'b00;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WB, CLEAR, DONE, INVAL} state_t;
`else
  localparam logic [1:0] CLR_VAL = 2'b01;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WB, CLEAR, DONE} state_t;
`endif

  state_t           state;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic [NWAY-1:0]  pending;
  logic [NWAY-1:0]  row_dv;
  logic [WAY_W-1:0] low_way;

  always_comb begin
    row_dv = '0;
    for (int unsigned w = 0; w < NWAY; w++)
      row_dv[w] = bus.i_dv_row_16[2*w+1] & bus.i_dv_row_16[2*w];
  end

  // Descending scan so the last hit is the lowest-index pending way.
  always_comb begin
    low_way = '0;
    for (int unsigned w = NWAY; w > 0; w--)
      if (pending[w-1]) low_way = WAY_W'(w - 1);
  end

  always_ff @(posedge fire or negedge rstn) begin
    if (!rstn) begin
      state                 <= IDLE;
      set_q                 <= '0;
      way_q                 <= '0;
      pending               <= '0;
      bus.o_flush_busy      <= 1'b0;
      bus.o_flush_done      <= 1'b0;
      bus.o_dv_addr_8       <= '0;
      bus.o_dv_write_enable <= 1'b0;
      bus.o_dv_data_in_2    <= '0;
      bus.o_wb_req          <= 1'b0;
      bus.o_wb_addr_8       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_flush_req) begin
            state            <= LOAD;
            set_q            <= '0;
            bus.o_flush_busy <= 1'b1;
            bus.o_dv_addr_8  <= '0;
          end
        end
        LOAD: begin
          pending <= row_dv;
          state   <= SCAN;
        end
        SCAN: begin
          if (pending == '0) begin
`ifdef DCACHE_FLUSH_INVALIDATE_EN
            state                 <= INVAL;
            way_q                 <= '0;
            bus.o_dv_write_enable <= 1'b1;
            bus.o_dv_data_in_2    <= 2'b00;
            bus.o_dv_addr_8       <= {set_q, {WAY_W{1'b0}}};
`else
            if (set_q == '1) begin
              state            <= DONE;
              bus.o_flush_done <= 1'b1;
            end else begin
              set_q           <= set_q + SET_W'(1);
              bus.o_dv_addr_8 <= {set_q + SET_W'(1), {WAY_W{1'b0}}};
              state           <= LOAD;
            end
`endif
          end else begin
            way_q           <= low_way;
            bus.o_wb_req    <= 1'b1;
            bus.o_wb_addr_8 <= {set_q, low_way};
            state           <= WB;
          end
        end
        WB: begin
          if (bus.i_wb_ack) begin
            bus.o_wb_req          <= 1'b0;
            bus.o_wb_addr_8       <= '0;
            bus.o_dv_write_enable <= 1'b1;
            bus.o_dv_data_in_2    <= CLR_VAL;
            bus.o_dv_addr_8       <= {set_q, way_q};
            state                 <= CLEAR;
          end
        end
        CLEAR: begin
          bus.o_dv_write_enable <= 1'b0;
          bus.o_dv_data_in_2    <= '0;
          pending[way_q]        <= 1'b0;
          state                 <= SCAN;
        end
`ifdef DCACHE_FLUSH_INVALIDATE_EN
        INVAL: begin
          if (way_q == '1) begin
            bus.o_dv_write_enable <= 1'b0;
            bus.o_dv_data_in_2    <= '0;
            if (set_q == '1) begin
              state            <= DONE;
              bus.o_flush_done <= 1'b1;
            end else begin
              set_q           <= set_q + SET_W'(1);
              bus.o_dv_addr_8 <= {set_q + SET_W'(1), {WAY_W{1'b0}}};
              state           <= LOAD;
            end
          end else begin
            way_q           <= way_q + WAY_W'(1);
            bus.o_dv_addr_8 <= {set_q, way_q + WAY_W'(1)};
          end
        end
`endif
        DONE: begin
          bus.o_flush_done <= 1'b0;
          bus.o_flush_busy <= 1'b0;
          bus.o_dv_addr_8  <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dv_flush_engine.sv
// Bench for dcache_dv_flush_engine: D/V buffer and write-back responder
// models, directed vector table, reset-mid-WB sequence and random images.
module tb_dcache_dv_flush_engine;
  localparam int NS = 32;
  localparam int NW = 8;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic fire = 1'b0;
  logic rstn = 1'b0;
  always #5 fire = ~fire;

  dcache_dv_flush_engine_if #(.SET_W(5), .WAY_W(3)) bus ();
  dcache_dv_flush_engine #(.SET_W(5), .WAY_W(3)) dut (
    .fire (fire),
    .rstn (rstn),
    .bus  (bus.master)
  );

  logic [1:0] mem  [NS][NW];
  logic [1:0] img  [NS][NW];
  logic [1:0] emem [NS][NW];
  logic       fill_go   = 1'b0;
  logic       start_req = 1'b0;
  logic       noise_req = 1'b0;
  logic       resp_ack  = 1'b0;
  logic       noise_ack = 1'b0;
  bit         noise_en  = 1'b0;
  int         ack_lat   = 1;
  int         ack_cnt   = 0;
  int         done_cnt  = 0;
  int         total = 0;
  int         bad   = 0;
  int         ecyc;
  logic [7:0] wb_q [$];
  logic [9:0] wr_q [$];
  logic [7:0] ewb  [$];
  logic [9:0] ewr  [$];

  assign bus.i_flush_req = start_req | noise_req;
  assign bus.i_wb_ack    = resp_ack | noise_ack;

  for (genvar g = 0; g < NW; g++) begin : g_row
    assign bus.i_dv_row_16[2*g+1:2*g] = mem[bus.o_dv_addr_8[7:3]][g];
  end

  // Buffer storage: image load while idle, engine writes while flushing.
  always @(posedge fire) begin
    if (fill_go) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++) mem[s][w] = img[s][w];
    end else if (rstn && bus.o_dv_write_enable) begin
      mem[bus.o_dv_addr_8[7:3]][bus.o_dv_addr_8[2:0]] = bus.o_dv_data_in_2;
      wr_q.push_back({bus.o_dv_addr_8, bus.o_dv_data_in_2});
    end
  end

  // Write-back responder acks in the ack_lat-th request cycle; optional noise.
  always @(negedge fire) begin
    if (bus.o_wb_req) begin
      ack_cnt++;
      resp_ack = (ack_cnt == ack_lat);
      if (resp_ack) wb_q.push_back(bus.o_wb_addr_8);
    end else begin
      ack_cnt  = 0;
      resp_ack = 1'b0;
    end
    noise_ack = noise_en && !bus.o_wb_req && ($urandom_range(0, 2) == 0);
    noise_req = noise_en && bus.o_flush_busy && !bus.o_flush_done &&
                ($urandom_range(0, 3) == 0);
    if (bus.o_flush_done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] row_mem(input int s);
    logic [15:0] r;
    for (int w = 0; w < NW; w++) r[2*w +: 2] = mem[s][w];
    return r;
  endfunction

  function automatic logic [15:0] row_emem(input int s);
    logic [15:0] r;
    for (int w = 0; w < NW; w++) r[2*w +: 2] = emem[s][w];
    return r;
  endfunction

  task automatic fill_all(input logic [15:0] pat);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) img[s][w] = pat[2*w +: 2];
  endtask

  task automatic set_row(input int s, input logic [15:0] r);
    for (int w = 0; w < NW; w++) img[s][w] = r[2*w +: 2];
  endtask

  task automatic load_image();
    @(negedge fire);
    fill_go = 1'b1;
    @(posedge fire);
    #1 fill_go = 1'b0;
  endtask

  // Reference: walk the image line by line, ascending set then way.
  task automatic model(input int lat);
    logic [1:0] cv;
    cv = INV ? 2'b00 : 2'b01;
    ewb.delete();
    ewr.delete();
    ecyc = 1;
    for (int s = 0; s < NS; s++) begin
      ecyc += 2;
      for (int w = 0; w < NW; w++) begin
        emem[s][w] = mem[s][w];
        if (mem[s][w] == 2'b11) begin
          ewb.push_back({5'(s), 3'(w)});
          ewr.push_back({5'(s), 3'(w), cv});
          emem[s][w] = cv;
          ecyc += lat + 2;
        end
      end
      if (INV) begin
        for (int w = 0; w < NW; w++) begin
          ewr.push_back({5'(s), 3'(w), 2'b00});
          emem[s][w] = 2'b00;
        end
        ecyc += 8;
      end
    end
  endtask

  task automatic run_flush(input int lat, input bit noise, output int cyc);
    ack_lat  = lat;
    noise_en = 1'b0;
    @(negedge fire);
    start_req = 1'b1;
    @(posedge fire);
    #1 start_req = 1'b0;
    noise_en = noise;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge fire);
      #1;
      cyc++;
      if (cyc == 1) chk("busy_cycle1", bus.o_flush_busy, 1);
      if (bus.o_flush_done) break;
    end
    chk("done_seen", bus.o_flush_done, 1);
    chk("busy_at_done", bus.o_flush_busy, 1);
    noise_en = 1'b0;
    repeat (3) @(negedge fire);
    #1;
  endtask

  task automatic compare_all(input int cyc, input int wb0, input int wr0, input int dn0);
    chk("done_cycle", cyc, ecyc);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("busy_after", bus.o_flush_busy, 0);
    chk("wb_count", wb_q.size() - wb0, ewb.size());
    for (int i = 0; i < ewb.size() && wb0 + i < wb_q.size(); i++)
      chk("wb_addr", wb_q[wb0+i], ewb[i]);
    chk("wr_count", wr_q.size() - wr0, ewr.size());
    for (int i = 0; i < ewr.size() && wr0 + i < wr_q.size(); i++)
      chk("wr_addr_data", wr_q[wr0+i], ewr[i]);
    for (int s = 0; s < NS; s++) chk("row_after", row_mem(s), row_emem(s));
  endtask

  typedef struct {
    logic [15:0] fill;
    int          set_idx;
    logic [15:0] row;
    int          lat;
    int          cyc_off;
    int          cyc_on;
    int          nwb;
    logic [15:0] row_after;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cyc, wb0, wr0, dn0, lat;
    logic [15:0] r;

    tbl[0] = '{16'h5555, 0,  16'h5555, 1, 65, 321, 0, 16'h5555};
    tbl[1] = '{16'h5555, 3,  16'h000F, 3, 75, 331, 2, 16'h0005};
    tbl[2] = '{16'h5555, 0,  16'h8000, 2, 65, 321, 0, 16'h8000};
    tbl[3] = '{16'h5555, 31, 16'hC003, 1, 71, 327, 2, 16'h4001};
    tbl[4] = '{16'h0000, 5,  16'hFFFF, 1, 89, 345, 8, 16'h5555};

    repeat (3) @(negedge fire);
    chk("rst_busy", bus.o_flush_busy, 0);
    chk("rst_done", bus.o_flush_done, 0);
    chk("rst_wb_req", bus.o_wb_req, 0);
    chk("rst_we", bus.o_dv_write_enable, 0);
    chk("rst_addr", bus.o_dv_addr_8, 0);
    chk("rst_wb_addr", bus.o_wb_addr_8, 0);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fill_all(tbl[i].fill);
      set_row(tbl[i].set_idx, tbl[i].row);
      load_image();
      model(tbl[i].lat);
      wb0 = wb_q.size(); wr0 = wr_q.size(); dn0 = done_cnt;
      run_flush(tbl[i].lat, i == 1, cyc);
      compare_all(cyc, wb0, wr0, dn0);
      chk("tbl_cycles", cyc, INV ? tbl[i].cyc_on : tbl[i].cyc_off);
      chk("tbl_wb", wb_q.size() - wb0, tbl[i].nwb);
      chk("tbl_row", row_mem(tbl[i].set_idx), INV ? 16'h0000 : tbl[i].row_after);
    end

    // Reset while a write-back is outstanding, then a clean restart.
    fill_all(16'h5555);
    set_row(0, 16'h0003);
    load_image();
    ack_lat = 1000;
    @(negedge fire);
    start_req = 1'b1;
    @(posedge fire);
    #1 start_req = 1'b0;
    for (int k = 0; k < 200 && !bus.o_wb_req; k++) @(negedge fire);
    chk("rst_req_seen", bus.o_wb_req, 1);
    @(negedge fire);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_wb_req", bus.o_wb_req, 0);
    chk("midrst_busy", bus.o_flush_busy, 0);
    chk("midrst_we", bus.o_dv_write_enable, 0);
    chk("midrst_row0", row_mem(0), 16'h0003);
    @(negedge fire);
    rstn = 1'b1;
    model(1);
    wb0 = wb_q.size(); wr0 = wr_q.size(); dn0 = done_cnt;
    run_flush(1, 1'b0, cyc);
    compare_all(cyc, wb0, wr0, dn0);
    chk("restart_first_wb", (wb_q.size() > wb0) ? wb_q[wb0] : 8'hFF, 8'h00);

    for (int n = 0; n < 6; n++) begin
      for (int s = 0; s < NS; s++) begin
        for (int w = 0; w < NW; w++) begin
          case ($urandom_range(0, 9))
            6:       r[2*w +: 2] = 2'b00;
            7:       r[2*w +: 2] = 2'b10;
            8, 9:    r[2*w +: 2] = 2'b11;
            default: r[2*w +: 2] = 2'b01;
          endcase
        end
        set_row(s, r);
      end
      load_image();
      lat = $urandom_range(1, 4);
      model(lat);
      wb0 = wb_q.size(); wr0 = wr_q.size(); dn0 = done_cnt;
      run_flush(lat, 1'b1, cyc);
      compare_all(cyc, wb0, wr0, dn0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
